// File: rtl/sub_pkg.sv
// rtl/sub_pkg.sv - shared state encoding and default width for the serial subtractor
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SUB_WIDTH = 8;

endpackage

// File: rtl/full_sub_cell.sv
// rtl/full_sub_cell.sv - combinational 1-bit full subtractor: d = x - y - z, bo = borrow out
module full_sub_cell (
  input  logic x,
  input  logic y,
  input  logic z,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ z;
  assign bo = (~x & y) | (~x & z) | (y & z);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial WIDTH-bit subtractor, LSB first, one full_sub_cell plus borrow flop
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] res;
  logic             brw;
  logic [CNT_W-1:0] cnt;
  logic             cell_d;
  logic             cell_bo;

  full_sub_cell u_cell (
    .x  (sa[0]),
    .y  (sb[0]),
    .z  (brw),
    .d  (cell_d),
    .bo (cell_bo)
  );

  // diff/borrow_out are written only on the last RUN edge so partial sums never leak out
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      sa         <= '0;
      sb         <= '0;
      res        <= '0;
      brw        <= 1'b0;
      cnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sa    <= a;
            sb    <= b;
            brw   <= bin;
            cnt   <= '0;
            res   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          brw <= cell_bo;
          res <= {cell_d, res[WIDTH-1:1]};
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
            diff       <= {cell_d, res[WIDTH-1:1]};
            borrow_out <= cell_bo;
            done       <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - scoreboard bench for serial_subtractor with an arithmetic reference model
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow_out;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .bin        (bin),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_done   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%h expected=%h at %0t", name, act, exp, $time);
  endtask

  // Reference model: an operation occupies WIDTH+2 cycles, result is plain 9-bit arithmetic
  logic [W:0] exp_q[$];
  int         remain = 0;
  logic [W:0] cur = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      remain = 0;
      cur    = '0;
    end else if (remain == 0 && start) begin
      exp_q.push_back({1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin});
      remain = W + 1;
    end else if (remain > 0) begin
      remain--;
    end
  end

  // Monitor: handshake every cycle, result popped from the scoreboard on each done
  always @(negedge clk) begin
    if (!rst) begin
      if (remain == 1) begin
        if (exp_q.size() == 0) chk("scoreboard_empty_on_done", 1, 0);
        else cur = exp_q.pop_front();
      end
      if (done) n_done++;
      chk("busy_done", {30'd0, busy, done}, {30'd0, remain > 0, remain == 1});
      chk("result", {23'd0, borrow_out, diff}, {23'd0, cur});
    end
  end

  task automatic wait_done(input string name);
    int got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1;
    end
    chk({name, "_done_seen"}, got, 1);
  endtask

  task automatic run_op(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic bv_in, input logic [W-1:0] exp_d, input logic exp_b);
    @(negedge clk);
    a = av; b = bv; bin = bv_in; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(name);
    chk({name, "_diff"}, diff, exp_d);
    chk({name, "_borrow"}, borrow_out, exp_b);
    @(negedge clk);
    chk({name, "_busy_drop"}, busy, 0);
  endtask

  int base;

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {21'd0, busy, done, borrow_out, diff}, 32'd0);
    rst = 1'b0;

    run_op("t1", 8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0);
    run_op("t2a", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1);
    repeat (3) @(negedge clk);
    chk("t2_hold", diff, 8'hFF);
    run_op("t2b", 8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0);
    run_op("t3a", 8'h10, 8'h10, 1'b1, 8'hFF, 1'b1);
    run_op("t3b", 8'h10, 8'h10, 1'b0, 8'h00, 1'b0);

    // start while busy is ignored and input churn does not disturb the operation
    base = n_done;
    @(negedge clk);
    a = 8'h80; b = 8'h01; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    a = 8'h00; b = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 8'h33; b = 8'hC4; bin = 1'b1;
    wait_done("t4");
    chk("t4_diff", diff, 8'h7F);
    chk("t4_borrow", borrow_out, 0);
    repeat (12) @(negedge clk);
    chk("t4_one_done", n_done - base, 1);

    // asynchronous reset mid-operation
    @(negedge clk);
    a = 8'h12; b = 8'h34; bin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1 chk("t5_async_reset", {21'd0, busy, done, borrow_out, diff}, 32'd0);
    base = n_done;
    @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    chk("t5_no_done", n_done - base, 0);
    run_op("t5b", 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1);

    // start held high: back-to-back operations every WIDTH+2 cycles
    base = n_done;
    @(negedge clk);
    a = 8'h09; b = 8'h04; bin = 1'b0; start = 1'b1;
    repeat (30) @(negedge clk);
    start = 1'b0;
    chk("t6_done_count", n_done - base, 3);
    chk("t6_diff", diff, 8'h05);
    repeat (12) @(negedge clk);

    // randomized traffic with starts arriving both idle and busy
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) == 0);
      a     = W'($urandom);
      b     = W'($urandom);
      bin   = 1'($urandom);
    end
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
